// File: rtl/mxv_pkg.sv
// Shared types and defaults for the command serializer.
package mxv_pkg;

    localparam int unsigned DEF_DW        = 8;
    localparam int unsigned DEF_CMD_WORDS = 3;
    localparam int unsigned MAX_CMD_WORDS = 16;
    localparam int unsigned COUNT_W       = $clog2(MAX_CMD_WORDS);

    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/cmd_word_index.sv
// Word index counter: increments on enable, returns to 0 after the terminal count or on clear.
module cmd_word_index
    import mxv_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   clr,
    input  count_t tc,
    output count_t count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == tc) begin
                count <= '0;
            end else begin
                count <= count + count_t'(1);
            end
        end
    end

endmodule

// File: rtl/cmd_serializer.sv
// Splits a registered multi-word command into a valid/ready word stream with last and done flags.
// Optional o_parity output is enabled by defining CMD_SERIALIZER_PARITY_EN.
module cmd_serializer
    import mxv_pkg::*;
#(
    parameter int unsigned DW        = DEF_DW,
    parameter int unsigned CMD_WORDS = DEF_CMD_WORDS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_cmd_valid,
    input  logic [CMD_WORDS*DW-1:0] i_cmd,
    output logic                    o_cmd_ready,
    input  logic                    i_clear,
    output logic [DW-1:0]           o_word,
    output logic                    o_word_valid,
    input  logic                    i_word_ready,
    output logic                    o_last,
    output count_t                  o_count,
`ifdef CMD_SERIALIZER_PARITY_EN
    output logic                    o_parity,
`endif
    output logic                    o_done
);

    localparam count_t TC = count_t'(CMD_WORDS - 1);

    state_t          state_q;
    state_t          state_d;
    logic            done_q;
    logic            done_d;
    logic            sending;
    logic            accept;
    logic            xfer;
    logic            at_last;
    count_t          idx;
    logic [DW-1:0]   words_q [CMD_WORDS];
    logic [DW-1:0]   word_sel;

    assign sending     = (state_q == ST_SEND);
    assign o_cmd_ready = (state_q == ST_IDLE) && !i_clear;
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign xfer        = sending && i_word_ready;
    assign at_last     = sending && (idx == TC);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Next state; clear overrides everything and suppresses the done pulse
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (i_clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (xfer && at_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Index restarts on accept so every command begins at word 0
    cmd_word_index u_index (
        .clk   (clk),
        .rst   (rst),
        .en    (xfer && !i_clear),
        .clr   (i_clear || accept),
        .tc    (TC),
        .count (idx)
    );

    // Command register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(CMD_WORDS); k++) begin
                words_q[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < int'(CMD_WORDS); k++) begin
                words_q[k] <= i_cmd[k*DW +: DW];
            end
        end
    end

    // Word multiplexer, forced to zero outside SEND
    always_comb begin
        word_sel = '0;
        if (sending) begin
            for (int k = 0; k < int'(CMD_WORDS); k++) begin
                if (idx == count_t'(k)) begin
                    word_sel = words_q[k];
                end
            end
        end
    end

    assign o_word       = word_sel;
    assign o_word_valid = sending;
    assign o_last       = at_last;
    assign o_count      = sending ? idx : '0;
    assign o_done       = done_q;

`ifdef CMD_SERIALIZER_PARITY_EN
    assign o_parity = sending ? ^word_sel : 1'b0;
`endif

endmodule

// File: tb/tb_cmd_serializer.sv
// Self-checking bench for cmd_serializer: directed scenarios plus a queue-based random reference model.
module tb_cmd_serializer;
    import mxv_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned NW = 3;
    localparam logic [NW*DW-1:0] CMD_A = 24'h332211;
    localparam logic [NW*DW-1:0] CMD_B = 24'hC6B5A4;

    logic              clk;
    logic              rst;
    logic              i_cmd_valid;
    logic [NW*DW-1:0]  i_cmd;
    logic              o_cmd_ready;
    logic              i_clear;
    logic [DW-1:0]     o_word;
    logic              o_word_valid;
    logic              i_word_ready;
    logic              o_last;
    count_t            o_count;
    logic              o_done;
`ifdef CMD_SERIALIZER_PARITY_EN
    logic              o_parity;
`endif

    int n_run;
    int n_fail;

    wire [14:0] snap = {o_word_valid, o_word, o_count, o_last, o_done};

    cmd_serializer #(.DW(DW), .CMD_WORDS(NW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cmd_valid  (i_cmd_valid),
        .i_cmd        (i_cmd),
        .o_cmd_ready  (o_cmd_ready),
        .i_clear      (i_clear),
        .o_word       (o_word),
        .o_word_valid (o_word_valid),
        .i_word_ready (i_word_ready),
        .o_last       (o_last),
        .o_count      (o_count),
`ifdef CMD_SERIALIZER_PARITY_EN
        .o_parity     (o_parity),
`endif
        .o_done       (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] exp_snap(bit v, logic [7:0] w, int c, bit l, bit d);
        return {v, w, count_t'(c), l, d};
    endfunction

    function automatic logic [7:0] word_of(logic [NW*DW-1:0] c, int j);
        logic [NW*DW-1:0] s;
        s = c >> (8 * j);
        return s[7:0];
    endfunction

    task automatic test_reset();
        #1;
        n_run++;
        if (snap !== exp_snap(0, 8'h00, 0, 0, 0)) begin
            n_fail++; $display("FAIL reset_outputs: got %h want %h", snap, exp_snap(0, 8'h00, 0, 0, 0));
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_run++;
        if (o_cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b want 1", o_cmd_ready);
        end
    endtask

    task automatic test_stream();
        @(negedge clk);
        i_cmd = CMD_A; i_cmd_valid = 1'b1; i_word_ready = 1'b1;
        #1;
        n_run++;
        if (o_cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL stream_ready: got %b want 1", o_cmd_ready);
        end
        @(negedge clk);
        i_cmd_valid = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_run++;
            if (snap !== exp_snap(1, word_of(CMD_A, k), k, k == 2, 0)) begin
                n_fail++; $display("FAIL stream_word%0d: got %h want %h", k, snap, exp_snap(1, word_of(CMD_A, k), k, k == 2, 0));
            end
            n_run++;
            if (o_cmd_ready !== 1'b0) begin
                n_fail++; $display("FAIL stream_busy%0d: got %b want 0", k, o_cmd_ready);
            end
            @(negedge clk);
            #1;
        end
        n_run++;
        if (snap !== exp_snap(0, 8'h00, 0, 0, 1)) begin
            n_fail++; $display("FAIL stream_done: got %h want %h", snap, exp_snap(0, 8'h00, 0, 0, 1));
        end
        @(negedge clk);
        #1;
        n_run++;
        if (o_done !== 1'b0) begin
            n_fail++; $display("FAIL stream_done_width: got %b want 0", o_done);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        i_cmd = CMD_A; i_cmd_valid = 1'b1; i_word_ready = 1'b1;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        #1;
        n_run++;
        if (snap !== exp_snap(1, 8'h11, 0, 0, 0)) begin
            n_fail++; $display("FAIL stall_w0: got %h want %h", snap, exp_snap(1, 8'h11, 0, 0, 0));
        end
        @(negedge clk);
        i_word_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_run++;
            if (snap !== exp_snap(1, 8'h22, 1, 0, 0)) begin
                n_fail++; $display("FAIL stall_hold%0d: got %h want %h", i, snap, exp_snap(1, 8'h22, 1, 0, 0));
            end
            @(negedge clk);
        end
        i_word_ready = 1'b1;
        #1;
        n_run++;
        if (snap !== exp_snap(1, 8'h22, 1, 0, 0)) begin
            n_fail++; $display("FAIL stall_w1: got %h want %h", snap, exp_snap(1, 8'h22, 1, 0, 0));
        end
        @(negedge clk);
        #1;
        n_run++;
        if (snap !== exp_snap(1, 8'h33, 2, 1, 0)) begin
            n_fail++; $display("FAIL stall_w2: got %h want %h", snap, exp_snap(1, 8'h33, 2, 1, 0));
        end
        @(negedge clk);
        #1;
        n_run++;
        if (snap !== exp_snap(0, 8'h00, 0, 0, 1)) begin
            n_fail++; $display("FAIL stall_done: got %h want %h", snap, exp_snap(0, 8'h00, 0, 0, 1));
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        i_cmd = CMD_A; i_cmd_valid = 1'b1; i_word_ready = 1'b1;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        @(negedge clk);
        i_clear = 1'b1;
        #1;
        n_run++;
        if (snap !== exp_snap(1, 8'h22, 1, 0, 0)) begin
            n_fail++; $display("FAIL clear_inflight: got %h want %h", snap, exp_snap(1, 8'h22, 1, 0, 0));
        end
        @(negedge clk);
        i_clear = 1'b0;
        #1;
        n_run++;
        if (snap !== exp_snap(0, 8'h00, 0, 0, 0)) begin
            n_fail++; $display("FAIL clear_abort: got %h want %h", snap, exp_snap(0, 8'h00, 0, 0, 0));
        end
        n_run++;
        if (o_cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL clear_ready: got %b want 1", o_cmd_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_run++;
            if (o_done !== 1'b0) begin
                n_fail++; $display("FAIL clear_nodone%0d: got %b want 0", i, o_done);
            end
        end
        @(negedge clk);
        i_clear = 1'b1; i_cmd_valid = 1'b1;
        #1;
        n_run++;
        if (o_cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL clear_idle_ready: got %b want 0", o_cmd_ready);
        end
        @(negedge clk);
        i_clear = 1'b0; i_cmd_valid = 1'b0;
        #1;
        n_run++;
        if (o_word_valid !== 1'b0) begin
            n_fail++; $display("FAIL clear_idle_noaccept: got %b want 0", o_word_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [NW*DW-1:0] cur;
        bit v;
        int j;
        @(negedge clk);
        i_word_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            i_cmd       = (c < 4) ? CMD_A : CMD_B;
            i_cmd_valid = (c < 8);
            cur = (c < 4) ? CMD_A : CMD_B;
            v   = (c % 4) != 0;
            j   = v ? (c % 4) - 1 : 0;
            #1;
            n_run++;
            if (snap !== exp_snap(v, v ? word_of(cur, j) : 8'h00, j, v && j == 2, c == 4 || c == 8)) begin
                n_fail++; $display("FAIL b2b_c%0d: got %h want %h", c, snap,
                    exp_snap(v, v ? word_of(cur, j) : 8'h00, j, v && j == 2, c == 4 || c == 8));
            end
            n_run++;
            if (o_cmd_ready !== !v) begin
                n_fail++; $display("FAIL b2b_ready_c%0d: got %b want %b", c, o_cmd_ready, !v);
            end
            @(negedge clk);
        end
        i_cmd_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        i_cmd = CMD_A; i_cmd_valid = 1'b1; i_word_ready = 1'b1;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_word_ready = 1'b0;
        #1;
        n_run++;
        if (snap !== exp_snap(1, 8'h33, 2, 1, 0)) begin
            n_fail++; $display("FAIL rstmid_w2: got %h want %h", snap, exp_snap(1, 8'h33, 2, 1, 0));
        end
        #2;
        rst = 1'b0;
        #1;
        n_run++;
        if (snap !== exp_snap(0, 8'h00, 0, 0, 0)) begin
            n_fail++; $display("FAIL rstmid_zero: got %h want %h", snap, exp_snap(0, 8'h00, 0, 0, 0));
        end
        @(negedge clk);
        rst = 1'b1; i_word_ready = 1'b1;
        #1;
        n_run++;
        if ({o_cmd_ready, o_done, o_word_valid} !== 3'b100) begin
            n_fail++; $display("FAIL rstmid_release: got %b want 100", {o_cmd_ready, o_done, o_word_valid});
        end
        @(negedge clk);
        #1;
        n_run++;
        if (o_done !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_nodone: got %b want 0", o_done);
        end
    endtask

`ifdef CMD_SERIALIZER_PARITY_EN
    task automatic test_parity();
        @(negedge clk);
        i_cmd = 24'h000307; i_cmd_valid = 1'b1; i_word_ready = 1'b1;
        #1;
        n_run++;
        if (o_parity !== 1'b0) begin
            n_fail++; $display("FAIL parity_idle: got %b want 0", o_parity);
        end
        @(negedge clk);
        i_cmd_valid = 1'b0;
        #1;
        n_run++;
        if (o_parity !== 1'b1) begin
            n_fail++; $display("FAIL parity_07: got %b want 1", o_parity);
        end
        @(negedge clk);
        #1;
        n_run++;
        if (o_parity !== 1'b0) begin
            n_fail++; $display("FAIL parity_03: got %b want 0", o_parity);
        end
        @(negedge clk);
        @(negedge clk);
    endtask
`endif

    // Reference: a command is a queue of pending words; the block is idle whenever the queue is empty
    task automatic test_random();
        logic [7:0] q[$];
        bit exp_done;
        bit nxt_done;
        bit exp_ready;
        bit v;
        @(negedge clk);
        i_clear = 1'b1; i_cmd_valid = 1'b0;
        @(negedge clk);
        i_clear = 1'b0;
        exp_done = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            i_cmd        = NW*DW'($urandom);
            i_cmd_valid  = ($urandom_range(0, 1) == 1);
            i_word_ready = ($urandom_range(0, 9) < 6);
            i_clear      = ($urandom_range(0, 19) == 0);
            #1;
            v = q.size() != 0;
            exp_ready = !v && !i_clear;
            n_run++;
            if (snap !== exp_snap(v, v ? q[0] : 8'h00, v ? int'(NW) - q.size() : 0, q.size() == 1, exp_done)) begin
                n_fail++; $display("FAIL rand_c%0d: got %h want %h", cyc, snap,
                    exp_snap(v, v ? q[0] : 8'h00, v ? int'(NW) - q.size() : 0, q.size() == 1, exp_done));
            end
            n_run++;
            if (o_cmd_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_ready_c%0d: got %b want %b", cyc, o_cmd_ready, exp_ready);
            end
            nxt_done = 1'b0;
            if (i_clear) begin
                q.delete();
            end else if (v) begin
                if (i_word_ready) begin
                    void'(q.pop_front());
                    nxt_done = (q.size() == 0);
                end
            end else if (i_cmd_valid) begin
                for (int j = 0; j < int'(NW); j++) q.push_back(word_of(i_cmd, j));
            end
            exp_done = nxt_done;
            @(negedge clk);
        end
        i_clear = 1'b0; i_cmd_valid = 1'b0;
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        rst = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd = '0;
        i_clear = 1'b0;
        i_word_ready = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_clear();
        test_back_to_back();
        test_reset_mid();
`ifdef CMD_SERIALIZER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_serializer.md
CMD_SERIALIZER -- requirements
Module: cmd_serializer

Interface
REQ-001 Parameter DW, default 8: width in bits of one command word.
REQ-002 Parameter CMD_WORDS, default 3: number of words per command; legal range 2..16.
REQ-003 clk  input  1  single clock for all sequential logic; rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 i_cmd_valid  input  1  upstream command present.
REQ-006 i_cmd  input  CMD_WORDS*DW  packed command; word 0 in bits [DW-1:0], word k in bits [(k+1)*DW-1:k*DW].
REQ-007 o_cmd_ready  output  1  upstream command can be accepted this cycle.
REQ-008 i_clear  input  1  synchronous abort of the command in flight.
REQ-009 o_word  output  DW  current outgoing word.
REQ-010 o_word_valid  output  1  o_word is valid.
REQ-011 i_word_ready  input  1  downstream accepts o_word this cycle.
REQ-012 o_last  output  1  o_word is the final word of the command.
REQ-013 o_count  output  count_t  index of the current word, 0..CMD_WORDS-1.
REQ-014 o_done  output  1  one-cycle pulse after the final word transfers.

Function
REQ-015 The state machine SHALL have two states, IDLE and SEND, and SHALL leave reset in IDLE.
REQ-016 o_cmd_ready SHALL be combinational: 1 only when the state is IDLE and i_clear=0.
REQ-017 Acceptance: when i_cmd_valid=1 and o_cmd_ready=1, the block SHALL register i_cmd, set the index to 0, and enter SEND on the next edge.
REQ-018 o_word_valid SHALL be 1 exactly when the state is SEND, giving one cycle of latency from acceptance to the first word.
REQ-019 o_word SHALL equal registered word[o_count], and o_count SHALL equal the index, in SEND; in IDLE, o_word=0 and o_count=0.
REQ-020 Transfer: when o_word_valid=1 and i_word_ready=1, the index SHALL increment on that edge.
REQ-021 While o_word_valid=1 and i_word_ready=0, o_word, o_count and o_last SHALL hold stable.
REQ-022 o_last SHALL be 1 exactly when the state is SEND and the index equals CMD_WORDS-1.
REQ-023 A transfer with o_last=1 SHALL return the state to IDLE, reset the index to 0, and pulse o_done=1 for one cycle on the next cycle.
REQ-024 o_cmd_ready SHALL be 0 throughout SEND, giving a minimum one-cycle bubble between commands.
REQ-025 i_clear=1 SHALL take priority over all other inputs and produce, on the next edge: state IDLE, index 0, and o_done=0 (no done pulse for an aborted command).
REQ-026 i_clear=1 in IDLE with i_cmd_valid=1 SHALL NOT accept the command.
REQ-027 The index SHALL never exceed CMD_WORDS-1 and SHALL never wrap while the state is SEND.

Reset
REQ-028 While rst=0, the block SHALL hold: state IDLE, index 0, command register 0, o_word_valid=0, o_last=0, o_done=0, o_count=0, o_word=0.
REQ-029 Reset asserted during SEND SHALL discard the command immediately, with no done pulse after release.
REQ-030 o_cmd_ready SHALL be 1 in the first cycle after reset release when i_clear=0.

Configuration
REQ-031 Macro CMD_SERIALIZER_PARITY_EN defined: output port o_parity (1 bit) SHALL exist and equal the XOR-reduction of o_word whenever o_word_valid=1, and 0 otherwise; it SHALL be combinational from the registered word.
REQ-032 Macro CMD_SERIALIZER_PARITY_EN undefined: the o_parity port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 The shared package mxv_pkg SHALL hold count_t, the default CMD_WORDS and DW constants, and the state enum type.
REQ-034 The word index SHALL be a sub-module, cmd_word_index, with enable, clear and terminal-count inputs and a registered count output.
REQ-035 The top level SHALL contain the state machine, the command register, the word multiplexer and the optional parity logic.

Verification
REQ-036 Reset, then i_cmd={8'h33,8'h22,8'h11} with valid=1 and i_word_ready=1 held -> words 11,22,33 on 3 consecutive cycles; o_count 0,1,2; o_last only on 33; o_done pulses 1 cycle later.
REQ-037 Same command, with i_word_ready=0 for 4 cycles during word 1 -> o_word=22 and o_count=1 held stable for those 4 cycles; no words lost or duplicated.
REQ-038 i_clear=1 while o_count=1 -> next cycle o_word_valid=0, o_count=0, o_done never pulses; o_cmd_ready=1 once i_clear=0.
REQ-039 Two commands back-to-back with i_cmd_valid held -> exactly one idle cycle between the o_last transfer of the first command and word 0 of the second.
REQ-040 rst pulsed low during word 2 -> all outputs 0 immediately; after release, o_cmd_ready=1 and o_done=0.
REQ-041 With CMD_SERIALIZER_PARITY_EN defined, word 8'h07 -> o_parity=1; word 8'h03 -> o_parity=0.
